// File: rtl/led_share_arbiter.sv
// Round-robin, dwell-limited arbiter sharing the three user LEDs between two
// pattern requesters. A prescaled tick measures the minimum grant length.
module led_share_arbiter #(
  parameter int unsigned TICK_DIV    = 12000000,
  parameter int unsigned DWELL_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] pat0,
  input  logic [2:0] pat1,
  output logic [1:0] gnt,
  output logic       tick,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5
);

  localparam int unsigned DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DwellW = $clog2(DWELL_TICKS + 1);

  localparam logic [DivW-1:0]   DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(DWELL_TICKS);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic                tick_q, tick_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [2:0]          led_q, led_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DivMax) ? '0 : div_cnt_q + 1'b1;
    tick_d    = (div_cnt_q == DivMax);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    case (state_q)
      StIdle: begin
        // With both requesting, the one not granted last wins.
        if (req[0] && (!req[1] || last_q)) begin
          state_d = StOwn0;
          last_d  = 1'b0;
          dwell_d = '0;
        end else if (req[1]) begin
          state_d = StOwn1;
          last_d  = 1'b1;
          dwell_d = '0;
        end
      end
      StOwn0: begin
        if (!req[0]) begin
          state_d = StIdle;
        end else if (dwell_q == DwellMax && req[1]) begin
          state_d = StOwn1;
          last_d  = 1'b1;
          dwell_d = '0;
        end else if (tick_q && dwell_q != DwellMax) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StOwn1: begin
        if (!req[1]) begin
          state_d = StIdle;
        end else if (dwell_q == DwellMax && req[0]) begin
          state_d = StOwn0;
          last_d  = 1'b0;
          dwell_d = '0;
        end else if (tick_q && dwell_q != DwellMax) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d = 2'b00;
    case (state_d)
      StOwn0:  gnt_d = 2'b01;
      StOwn1:  gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
    // LEDs follow the current owner, so they lag the grant by one edge.
    led_d = 3'b000;
    case (state_q)
      StOwn0:  led_d = pat0;
      StOwn1:  led_d = pat1;
      default: led_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      dwell_q   <= '0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      gnt_q     <= 2'b00;
      led_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      gnt_q     <= gnt_d;
      led_q     <= led_d;
    end
  end

  assign gnt  = gnt_q;
  assign tick = tick_q;
  assign LED3 = led_q[0];
  assign LED4 = led_q[1];
  assign LED5 = led_q[2];

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter: grant sequencing, LED latency,
// asynchronous reset and prescaler period for several TICK_DIV values.
module tb_led_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [2:0] pat0 = 3'b000;
  logic [2:0] pat1 = 3'b000;
  logic [1:0] gnt, gnt3, gnt1;
  logic       tick, tick3, tick1;
  logic       led3, led4, led5;
  logic       l3_3, l3_4, l3_5, l1_3, l1_4, l1_5;
  logic [2:0] leds;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign leds = {led5, led4, led3};

  led_share_arbiter #(.TICK_DIV(2), .DWELL_TICKS(2)) dut (
    .clk(clk), .rst(rst), .req(req), .pat0(pat0), .pat1(pat1),
    .gnt(gnt), .tick(tick), .LED3(led3), .LED4(led4), .LED5(led5)
  );

  led_share_arbiter #(.TICK_DIV(3), .DWELL_TICKS(2)) dut3 (
    .clk(clk), .rst(rst), .req(2'b00), .pat0(3'b000), .pat1(3'b000),
    .gnt(gnt3), .tick(tick3), .LED3(l3_3), .LED4(l3_4), .LED5(l3_5)
  );

  led_share_arbiter #(.TICK_DIV(1), .DWELL_TICKS(2)) dut1 (
    .clk(clk), .rst(rst), .req(2'b00), .pat0(3'b000), .pat1(3'b000),
    .gnt(gnt1), .tick(tick1), .LED3(l1_3), .LED4(l1_4), .LED5(l1_5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse reset between edges; the next posedge is edge 1 of a fresh run.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held.
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_tick1", 32'(tick1), 32'h0);

    // Contention from reset plus prescaler checks on all three instances.
    req  = 2'b11;
    pat0 = 3'b101;
    pat1 = 3'b011;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("cont_gnt_e%0d", k), 32'(gnt),
            (k <= 5) ? 32'h1 : (k <= 9) ? 32'h2 : 32'h1);
      check($sformatf("tick2_e%0d", k), 32'(tick), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("tick3_e%0d", k), 32'(tick3), (k % 3 == 0) ? 32'h1 : 32'h0);
      check($sformatf("tick1_e%0d", k), 32'(tick1), 32'h1);
      if (k == 2) check("cont_leds_e2", 32'(leds), 32'h5);
      if (k == 6) check("cont_leds_e6", 32'(leds), 32'h5);
      if (k == 7) check("cont_leds_e7", 32'(leds), 32'h3);
    end

    // Asynchronous reset mid-grant.
    req  = 2'b01;
    pat0 = 3'b101;
    do_reset();
    @(negedge clk);
    check("arst_gnt_pre", 32'(gnt), 32'h1);
    @(negedge clk);
    check("arst_leds_pre", 32'(leds), 32'h5);
    #1 rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_leds", 32'(leds), 32'h0);
    #1 rst = 1'b0;

    // Single requester with pattern change and release.
    req  = 2'b10;
    pat1 = 3'b011;
    do_reset();
    @(negedge clk);
    check("single_gnt_e1", 32'(gnt), 32'h2);
    check("single_leds_e1", 32'(leds), 32'h0);
    @(negedge clk);
    check("single_leds_e2", 32'(leds), 32'h3);
    pat1 = 3'b110;
    @(negedge clk);
    check("single_patchg", 32'(leds), 32'h6);
    req = 2'b00;
    @(negedge clk);
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_leds_hold", 32'(leds), 32'h6);
    @(negedge clk);
    check("single_rel_leds", 32'(leds), 32'h0);

    // Early release at dwell=1: one idle cycle, then the other side.
    req = 2'b11;
    do_reset();
    repeat (3) @(negedge clk);
    check("early_gnt_e3", 32'(gnt), 32'h1);
    req = 2'b10;
    @(negedge clk);
    check("early_gap", 32'(gnt), 32'h0);
    @(negedge clk);
    check("early_other", 32'(gnt), 32'h2);

    // Owner drop coinciding with dwell expiry: the drop wins.
    req = 2'b11;
    do_reset();
    repeat (5) @(negedge clk);
    check("drop_gnt_e5", 32'(gnt), 32'h1);
    req = 2'b10;
    @(negedge clk);
    check("drop_wins", 32'(gnt), 32'h0);
    @(negedge clk);
    check("drop_then_other", 32'(gnt), 32'h2);

    // No contender for 20 ticks; saturated dwell allows an immediate switch.
    req = 2'b01;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("hold_gnt_e%0d", k), 32'(gnt), 32'h1);
    end
    check("hold_dwell_sat", 32'(dut.dwell_q), 32'h2);
    req = 2'b11;
    @(negedge clk);
    check("sat_switch", 32'(gnt), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
